// File: rtl/norz_seq_pkg.sv
// Shared types and constants for the opcode phase sequencer.
// Holds the FSM state encoding and the default phase-counter limits.
package norz_seq_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        OPND  = 2'd2
    } seq_state_t;

    localparam int              XPT_WIDTH_DEFAULT    = 5;
    localparam int              OP_WIDTH_DEFAULT     = 8;
    localparam int              XPT_MAX              = 2**XPT_WIDTH_DEFAULT - 1;
    localparam logic [7:0]      DEFAULT_RESET_OPCODE = 8'h00;

endpackage

// File: rtl/dual_rail_reg.sv
// Register with a true and a complement rail, both flopped on the same edge.
// The complement is never derived combinationally, so both rails switch together.
module dual_rail_reg #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] not_q
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q     <= RESET_VALUE;
            not_q <= ~RESET_VALUE;
        end else if (load) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            q     <= d;
            not_q <= ~d;
        end
    end

endmodule

// File: rtl/op_phase_sequencer.sv
// Fetches an opcode byte, then steps the XPT phase count while the decoder tree
// is enabled, pausing for operand fetches and stalls until the decoders finish.
module op_phase_sequencer
    import norz_seq_pkg::*;
#(
    parameter int                  XPT_WIDTH    = XPT_WIDTH_DEFAULT,
    parameter int                  OP_WIDTH     = OP_WIDTH_DEFAULT,
    parameter logic [OP_WIDTH-1:0] RESET_OPCODE = OP_WIDTH'(DEFAULT_RESET_OPCODE)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [OP_WIDTH-1:0]  MemData,
    input  logic                 MemReady,
    input  logic                 Stall,
    input  logic                 PR_Reset_XPT,
    input  logic                 Pa_Ophd,
    output logic                 MemReq,
    output logic                 PC_Inc,
    output logic                 enable,
    output logic [OP_WIDTH-1:0]  Source,
    output logic [OP_WIDTH-1:0]  notSource,
    output logic [XPT_WIDTH-1:0] XPT,
    output logic [XPT_WIDTH-1:0] notXPT,
    output logic [OP_WIDTH-1:0]  Operand,
    output logic                 Overrun
);

    localparam logic [XPT_WIDTH-1:0] XPT_LIMIT = XPT_WIDTH'(2**XPT_WIDTH - 1);

    seq_state_t           state, state_next;
    logic                 xpt_load;
    logic [XPT_WIDTH-1:0] xpt_d;
    logic                 source_load;
    logic                 operand_load;
    logic                 overrun_set;
    logic                 byte_accepted;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            PC_Inc  <= 1'b0;
            Operand <= '0;
            Overrun <= 1'b0;
        end else begin
            state  <= state_next;
            PC_Inc <= byte_accepted;
            if (operand_load) Operand <= MemData;
            if (overrun_set)  Overrun <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        state_next    = state;
        xpt_load      = 1'b0;
        xpt_d         = XPT;
        source_load   = 1'b0;
        operand_load  = 1'b0;
        overrun_set   = 1'b0;
        byte_accepted = 1'b0;
        MemReq        = 1'b0;
        enable        = 1'b0;
        unique case (state)
            FETCH: begin
                MemReq = 1'b1;
                if (MemReady) begin
                    source_load   = 1'b1;
                    byte_accepted = 1'b1;
                    xpt_load      = 1'b1;
                    xpt_d         = '0;
                    state_next    = EXEC;
                end
            end
            EXEC: begin
                enable = 1'b1;
                // Limit check sits above the increment so the count never wraps.
                if (PR_Reset_XPT) begin
                    xpt_load   = 1'b1;
                    xpt_d      = '0;
                    state_next = FETCH;
                end else if (XPT == XPT_LIMIT) begin
                    overrun_set = 1'b1;
                    xpt_load    = 1'b1;
                    xpt_d       = '0;
                    state_next  = FETCH;
                end else if (Pa_Ophd) begin
                    state_next = OPND;
                end else if (!Stall) begin
                    xpt_load = 1'b1;
                    xpt_d    = XPT + XPT_WIDTH'(1);
                end
            end
            OPND: begin
                MemReq = 1'b1;
                if (MemReady) begin
                    operand_load  = 1'b1;
                    byte_accepted = 1'b1;
                    xpt_load      = 1'b1;
                    xpt_d         = XPT + XPT_WIDTH'(1);
                    state_next    = EXEC;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    dual_rail_reg #(
        .WIDTH       (OP_WIDTH),
        .RESET_VALUE (RESET_OPCODE)
    ) u_source_reg (
        .clock (clock),
        .reset (reset),
        .load  (source_load),
        .d     (MemData),
        .q     (Source),
        .not_q (notSource)
    );

    dual_rail_reg #(
        .WIDTH       (XPT_WIDTH),
        .RESET_VALUE ('0)
    ) u_xpt_reg (
        .clock (clock),
        .reset (reset),
        .load  (xpt_load),
        .d     (xpt_d),
        .q     (XPT),
        .not_q (notXPT)
    );

endmodule

// File: tb/tb_op_phase_sequencer.sv
// Directed bench for op_phase_sequencer: drives inputs and samples outputs on the
// falling edge, with hand-computed expectations and a per-cycle dual-rail check.
module tb_op_phase_sequencer;
    import norz_seq_pkg::*;

    logic       clock;
    logic       reset;
    logic [7:0] MemData;
    logic       MemReady;
    logic       Stall;
    logic       PR_Reset_XPT;
    logic       Pa_Ophd;
    logic       MemReq;
    logic       PC_Inc;
    logic       enable;
    logic [7:0] Source;
    logic [7:0] notSource;
    logic [4:0] XPT;
    logic [4:0] notXPT;
    logic [7:0] Operand;
    logic       Overrun;

    int checks_done = 0;
    int checks_failed = 0;
    int pulses = 0;

    op_phase_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .MemData      (MemData),
        .MemReady     (MemReady),
        .Stall        (Stall),
        .PR_Reset_XPT (PR_Reset_XPT),
        .Pa_Ophd      (Pa_Ophd),
        .MemReq       (MemReq),
        .PC_Inc       (PC_Inc),
        .enable       (enable),
        .Source       (Source),
        .notSource    (notSource),
        .XPT          (XPT),
        .notXPT       (notXPT),
        .Operand      (Operand),
        .Overrun      (Overrun)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_done++;
        if (observed !== expected) begin
            checks_failed++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        if (PC_Inc) pulses++;
    endtask

    // Complement rails must match on every sampled cycle, including reset.
    always @(negedge clock) begin
        logic [4:0] nx;
        logic [7:0] ns;
        nx = ~XPT;
        ns = ~Source;
        check("dual_xpt", notXPT, nx);
        check("dual_source", notSource, ns);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        MemData = 8'h00;
        MemReady = 1'b0;
        Stall = 1'b0;
        PR_Reset_XPT = 1'b0;
        Pa_Ophd = 1'b0;
        tick();
        tick();
        check("rst_source", Source, 8'h00);
        check("rst_not_source", notSource, 8'hFF);
        check("rst_xpt", XPT, 5'd0);
        check("rst_not_xpt", notXPT, 5'h1F);
        check("rst_enable", enable, 1'b0);
        check("rst_pc_inc", PC_Inc, 1'b0);
        check("rst_operand", Operand, 8'h00);
        check("rst_overrun", Overrun, 1'b0);
        check("rst_mem_req", MemReq, 1'b1);
        reset = 1'b0;

        // Opcode fetch, then four phases ending on PR_Reset_XPT at XPT=3
        MemData = 8'h0A; MemReady = 1'b1; pulses = 0;
        tick();
        MemReady = 1'b0;
        check("f1_source", Source, 8'h0A);
        check("f1_not_source", notSource, 8'hF5);
        check("f1_enable", enable, 1'b1);
        check("f1_xpt", XPT, 5'd0);
        check("f1_pc_inc", PC_Inc, 1'b1);
        check("f1_mem_req", MemReq, 1'b0);
        tick();
        check("f1_pc_inc_single", PC_Inc, 1'b0);
        check("f1_xpt1", XPT, 5'd1);
        tick();
        check("f1_xpt2", XPT, 5'd2);
        tick();
        check("f1_xpt3", XPT, 5'd3);
        PR_Reset_XPT = 1'b1;
        tick();
        PR_Reset_XPT = 1'b0;
        check("f1_done_xpt", XPT, 5'd0);
        check("f1_done_mem_req", MemReq, 1'b1);
        check("f1_done_enable", enable, 1'b0);
        check("f1_pulses", pulses, 1);

        // Operand fetch at XPT=1 with two memory wait cycles
        MemData = 8'h55; MemReady = 1'b1; pulses = 0;
        tick();
        MemReady = 1'b0;
        check("op_xpt0", XPT, 5'd0);
        tick();
        check("op_xpt1", XPT, 5'd1);
        Pa_Ophd = 1'b1;
        tick();
        Pa_Ophd = 1'b0;
        check("op_wait_enable", enable, 1'b0);
        check("op_wait_mem_req", MemReq, 1'b1);
        check("op_wait_xpt_a", XPT, 5'd1);
        tick();
        check("op_wait_xpt_b", XPT, 5'd1);
        tick();
        check("op_wait_xpt_c", XPT, 5'd1);
        MemData = 8'h34; MemReady = 1'b1;
        tick();
        MemReady = 1'b0;
        check("op_operand", Operand, 8'h34);
        check("op_xpt2", XPT, 5'd2);
        check("op_enable", enable, 1'b1);
        check("op_source_kept", Source, 8'h55);
        check("op_pc_inc", PC_Inc, 1'b1);
        check("op_pulses", pulses, 2);
        PR_Reset_XPT = 1'b1;
        tick();
        PR_Reset_XPT = 1'b0;
        check("op_done_mem_req", MemReq, 1'b1);

        // Stall holds XPT at 2; PR_Reset_XPT wins over a simultaneous Stall
        MemData = 8'h77; MemReady = 1'b1;
        tick();
        MemReady = 1'b0;
        tick();
        tick();
        check("st_xpt2", XPT, 5'd2);
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("st_hold_xpt", XPT, 5'd2);
            check("st_hold_enable", enable, 1'b1);
        end
        PR_Reset_XPT = 1'b1;
        tick();
        PR_Reset_XPT = 1'b0;
        Stall = 1'b0;
        check("st_done_xpt", XPT, 5'd0);
        check("st_done_mem_req", MemReq, 1'b1);
        check("st_done_enable", enable, 1'b0);

        // Runaway instruction: XPT climbs to the limit, then Overrun
        MemData = 8'h99; MemReady = 1'b1;
        tick();
        MemData = 8'hEE;
        tick();
        MemReady = 1'b0;
        check("ov_ready_ignored_src", Source, 8'h99);
        check("ov_ready_ignored_pc", PC_Inc, 1'b0);
        check("ov_xpt1", XPT, 5'd1);
        repeat (XPT_MAX - 1) tick();
        check("ov_xpt_max", XPT, 5'd31);
        check("ov_not_yet", Overrun, 1'b0);
        tick();
        check("ov_set", Overrun, 1'b1);
        check("ov_xpt0", XPT, 5'd0);
        check("ov_mem_req", MemReq, 1'b1);
        check("ov_enable", enable, 1'b0);
        MemData = 8'h12; MemReady = 1'b1;
        tick();
        MemReady = 1'b0;
        check("ov_next_source", Source, 8'h12);
        check("ov_next_enable", enable, 1'b1);
        PR_Reset_XPT = 1'b1;
        tick();
        PR_Reset_XPT = 1'b0;
        check("ov_sticky", Overrun, 1'b1);

        // Asynchronous reset while waiting for an operand
        MemData = 8'h21; MemReady = 1'b1;
        tick();
        MemReady = 1'b0;
        Pa_Ophd = 1'b1;
        tick();
        Pa_Ophd = 1'b0;
        check("ar_in_opnd", MemReq, 1'b1);
        check("ar_in_opnd_enable", enable, 1'b0);
        tick();
        #2 reset = 1'b1;
        #1;
        check("ar_source", Source, 8'h00);
        check("ar_not_source", notSource, 8'hFF);
        check("ar_xpt", XPT, 5'd0);
        check("ar_not_xpt", notXPT, 5'h1F);
        check("ar_enable", enable, 1'b0);
        check("ar_mem_req", MemReq, 1'b1);
        check("ar_operand", Operand, 8'h00);
        check("ar_overrun", Overrun, 1'b0);
        check("ar_pc_inc", PC_Inc, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        check("ar_after_mem_req", MemReq, 1'b1);
        check("ar_after_enable", enable, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks_done, checks_failed);
        $finish;
    end

endmodule
